// File: rtl/dmi_bus_adapter_if.sv
// dmi_bus_adapter_if: debug-transport request/response and register-bus signals of the adapter
interface dmi_bus_adapter_if;
  logic        debug_req_valid;
  logic        debug_req_ready;
  logic [6:0]  debug_req_bits_addr;
  logic [1:0]  debug_req_bits_op;
  logic [31:0] debug_req_bits_data;
  logic        debug_resp_valid;
  logic        debug_resp_ready;
  logic [1:0]  debug_resp_bits_resp;
  logic [31:0] debug_resp_bits_data;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [6:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  modport master (
    input  debug_req_valid, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data,
    input  debug_resp_ready, bus_gnt, bus_rvalid, bus_rdata, bus_err,
    output debug_req_ready, debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data,
    output bus_req, bus_we, bus_addr, bus_wdata
  );
  modport slave (
    output debug_req_valid, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data,
    output debug_resp_ready, bus_gnt, bus_rvalid, bus_rdata, bus_err,
    input  debug_req_ready, debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data,
    input  bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/dmi_bus_adapter.sv
// dmi_bus_adapter: bridges DMI requests onto a req/gnt/rvalid register bus with per-access timeout
module dmi_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic reset,
  dmi_bus_adapter_if.master dmi
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t      r_state;
  logic        r_ready;
  logic        r_resp_valid;
  logic        r_bus_req;
  logic        r_we;
  logic        r_outst;
  logic [1:0]  r_resp;
  logic [31:0] r_data;
  logic [31:0] r_wdata;
  logic [6:0]  r_addr;
  logic [15:0] r_cnt;
  logic [16:0] w_cnt_inc;
  logic        w_timeout;
  logic        w_accept;
  logic        w_bus_op;
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
  assign w_timeout = w_cnt_inc >= 17'(TIMEOUT_CYCLES);
  assign w_accept  = r_ready && dmi.debug_req_valid;
  assign w_bus_op  = dmi.debug_req_bits_op[0] ^ dmi.debug_req_bits_op[1];
  assign dmi.debug_req_ready      = r_ready;
  assign dmi.debug_resp_valid     = r_resp_valid;
  assign dmi.debug_resp_bits_resp = r_resp;
  assign dmi.debug_resp_bits_data = r_data;
  assign dmi.bus_req              = r_bus_req;
  assign dmi.bus_we               = r_we;
  assign dmi.bus_addr             = r_addr;
  assign dmi.bus_wdata            = r_wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_bus_req    <= 1'b0;
      r_we         <= 1'b0;
      r_outst      <= 1'b0;
      r_resp       <= 2'd0;
      r_data       <= '0;
      r_wdata      <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
    end else begin
      // a late completion of an aborted access is absorbed wherever it lands outside WAIT
      if (r_state != WAIT && dmi.bus_rvalid) r_outst <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= dmi.debug_req_bits_addr;
            r_wdata <= dmi.debug_req_bits_data;
            r_we    <= dmi.debug_req_bits_op == 2'd2;
            if (w_bus_op) begin
              r_state   <= REQ;
              r_bus_req <= 1'b1;
            end else begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp       <= (dmi.debug_req_bits_op == 2'd0) ? 2'd0 : 2'd2;
              r_data       <= '0;
            end
          end else r_ready <= !r_outst || dmi.bus_rvalid;
        end
        REQ: begin
          r_cnt <= w_cnt_inc[15:0];
          if (dmi.bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= WAIT;
          end else if (w_timeout) begin
            r_bus_req    <= 1'b0;
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp       <= 2'd3;
            r_data       <= '0;
          end
        end
        WAIT: begin
          r_cnt <= w_cnt_inc[15:0];
          if (dmi.bus_rvalid) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp       <= dmi.bus_err ? 2'd2 : 2'd0;
            r_data       <= (!r_we && !dmi.bus_err) ? dmi.bus_rdata : '0;
          end else if (w_timeout) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp       <= 2'd3;
            r_data       <= '0;
            r_outst      <= 1'b1;
          end
        end
        RESP: begin
          if (dmi.debug_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
            r_ready      <= !r_outst || dmi.bus_rvalid;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dmi_bus_adapter.md
DMI_BUS_ADAPTER -- requirements
Module: dmi_bus_adapter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 255, cycles allowed per bus access before abort (range 1..65535).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 debug_req_valid  input  1  DMI request valid from debug transport.
REQ-006 debug_req_ready  output  1  adapter accepts request.
REQ-007 debug_req_bits_addr  input  7  DMI register address.
REQ-008 debug_req_bits_op  input  2  0=nop, 1=read, 2=write, 3=reserved.
REQ-009 debug_req_bits_data  input  32  write data.
REQ-010 debug_resp_valid  output  1  response valid.
REQ-011 debug_resp_ready  input  1  transport accepts response.
REQ-012 debug_resp_bits_resp  output  2  0=success, 2=failed, 3=busy/timeout.
REQ-013 debug_resp_bits_data  output  32  read data.
REQ-014 bus_req  output  1  register-bus request, held until bus_gnt.
REQ-015 bus_gnt  input  1  register-bus grant.
REQ-016 bus_we  output  1  1=write, 0=read.
REQ-017 bus_addr  output  7  register address.
REQ-018 bus_wdata  output  32  write data.
REQ-019 bus_rvalid  input  1  access completion, at least 1 cycle after grant.
REQ-020 bus_rdata  input  32  read data, valid with bus_rvalid.
REQ-021 bus_err  input  1  access error, valid with bus_rvalid.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-023 debug_req_ready SHALL be 1 only in IDLE with no outstanding bus access (REQ-033); handshake = valid&&ready; addr/op/data latched on handshake.
REQ-024 Accepted op=0 SHALL go to RESP with resp=0, data=0, no bus access.
REQ-025 Accepted op=3 SHALL go to RESP with resp=2, data=0, no bus access.
REQ-026 Accepted op=1/2 SHALL go to REQ; bus_req=1, bus_we=(op==2), bus_addr/bus_wdata from latches, all stable until grant.
REQ-027 In REQ, cycle with bus_gnt=1 SHALL be last cycle of bus_req; next state WAIT.
REQ-028 bus_rvalid SHALL be sampled only in WAIT (and in IDLE for drain, REQ-033); on rvalid go to RESP with resp=(bus_err?2:0), data=(read && !bus_err ? bus_rdata : 0).
REQ-029 Timeout counter SHALL clear on request acceptance and increment every cycle in REQ or WAIT; on reaching TIMEOUT_CYCLES go to RESP with resp=3, data=0.
REQ-030 Completion (gnt in REQ, rvalid in WAIT) and timeout in the same cycle: completion SHALL win.
REQ-031 RESP: debug_resp_valid=1 with resp/data stable until debug_resp_ready=1; then IDLE next cycle. Minimum request-to-request spacing: read with immediate gnt and rvalid = 4 cycles.
REQ-032 Timeout in REQ SHALL deassert bus_req next cycle with no access outstanding.
REQ-033 Timeout in WAIT SHALL set outstanding flag; while set, debug_req_ready=0 and no new bus_req; a bus_rvalid clears it and its data/err are discarded.
REQ-034 debug_req_valid while not ready SHALL be ignored; no request queuing.

Reset
REQ-035 Reset SHALL force IDLE, outstanding=0, counter=0, and all outputs 0 (incl. debug_req_ready, bus_req, debug_resp_valid) in the cycle after reset is sampled.
REQ-036 Reset mid-transaction SHALL abandon it with no response; completions arriving after reset SHALL be ignored.
REQ-037 debug_req_ready SHALL first assert one cycle after reset deasserts.

Verification
REQ-038 Read addr 0x11, gnt immediate, rvalid next cycle rdata=0xDEADBEEF err=0 -> resp=0, data=0xDEADBEEF, bus_we=0, bus_addr=0x11.
REQ-039 Write addr 0x10 data 0x80000001, err=1 -> bus_we=1, bus_wdata=0x80000001, resp=2, data=0.
REQ-040 op=0 and op=3 -> no bus_req; resp=0 and resp=2 respectively, data=0.
REQ-041 TIMEOUT_CYCLES=4, gnt never asserted -> bus_req high exactly 4 cycles, resp=3; next request issues normally.
REQ-042 TIMEOUT_CYCLES=4, gnt then rvalid after 10 cycles -> resp=3; debug_req_ready=0 until late rvalid, its data discarded.
REQ-043 debug_resp_ready low 5 cycles, and reset asserted in WAIT -> resp held stable; after reset all outputs 0 and a later rvalid produces no response.
